io_pad_func_ctrl: RTL

//  Per-pad function arbiter and sequencer between NUM_FUNC requesters (func 0 = GPIO,
//  1..NUM_FUNC-1 = peripherals) and NUM_PAD tri-state pads.

---
 rtl/io_pkg.sv | 13 +
 rtl/io_pad_in_filter.sv | 50 +++++
 rtl/io_pad_func_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/io_pkg.sv
// Shared types and defaults for the pad function controller.
package io_pkg;

    localparam int unsigned FUNC_GPIO    = 0;
    localparam int unsigned DEAD_CYC_DEF = 4;
    localparam int unsigned FILT_CYC_DEF = 8;

    typedef enum logic {
        ST_ACTIVE = 1'b0,
        ST_DRAIN  = 1'b1
    } pad_state_e;

endpackage

// File: rtl/io_pad_in_filter.sv
// Pad input conditioning: 2-flop synchronizer followed by an optional debounce filter.
module io_pad_in_filter
    import io_pkg::*;
#(
    parameter int unsigned FILT_CYC = FILT_CYC_DEF,
    localparam int unsigned CNT_W   = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pad_i,
    input  logic filt_i,
    output logic val_nxt_c
);

    logic             r_s1;
    logic             r_s2;
    logic             r_val;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Value changes only after FILT_CYC consecutive differing samples; bypass passes s straight through.
    always_comb begin
        val_nxt_c = r_val;
        w_cnt_nxt = '0;
        if (!filt_i) begin
            val_nxt_c = r_s2;
        end else if (r_s2 != r_val) begin
            if (r_cnt == CNT_W'(FILT_CYC - 1)) begin
                val_nxt_c = r_s2;
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_val <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_s1  <= pad_i;
            r_s2  <= r_s1;
            r_val <= val_nxt_c;
            r_cnt <= w_cnt_nxt;
        end
    end

endmodule

// File: rtl/io_pad_func_ctrl.sv
// Per-pad function arbiter: selects one requester per pad, enforces a dead time on switches,
// and routes the conditioned pad input back to the active requester.
module io_pad_func_ctrl
    import io_pkg::*;
#(
    parameter int unsigned NUM_PAD  = 8,
    parameter int unsigned NUM_FUNC = 4,
    parameter int unsigned DEAD_CYC = DEAD_CYC_DEF,
    parameter int unsigned FILT_CYC = FILT_CYC_DEF,
    localparam int unsigned SEL_W   = $clog2(NUM_FUNC),
    localparam int unsigned IDX_W   = (NUM_PAD > 1) ? $clog2(NUM_PAD) : 1,
    localparam int unsigned DCNT_W  = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        cfg_we_i,
    input  logic [IDX_W-1:0]            cfg_idx_i,
    input  logic [SEL_W-1:0]            cfg_sel_i,
    input  logic                        cfg_filt_i,
    input  logic [NUM_PAD*NUM_FUNC-1:0] func_out_i,
    input  logic [NUM_PAD*NUM_FUNC-1:0] func_oen_i,
    output logic [NUM_PAD*NUM_FUNC-1:0] func_in_o,
    output logic [NUM_PAD-1:0]          pad_c2p_o,
    output logic [NUM_PAD-1:0]          pad_c2p_en_o,
    input  logic [NUM_PAD-1:0]          pad_p2c_i,
    output logic [NUM_PAD*SEL_W-1:0]    sel_o,
    output logic [NUM_PAD-1:0]          busy_o
);

    for (genvar p = 0; p < NUM_PAD; p++) begin : g_pad
        logic [NUM_FUNC-1:0] w_out;
        logic [NUM_FUNC-1:0] w_oen;
        logic [NUM_FUNC-1:0] w_sel_oh;
        logic                w_wr;
        logic                w_val_nxt;
        logic                w_nactive;
        pad_state_e          r_state;
        pad_state_e          w_nstate;
        logic [SEL_W-1:0]    r_sel;
        logic [SEL_W-1:0]    w_nsel;
        logic [SEL_W-1:0]    r_pend;
        logic [SEL_W-1:0]    w_npend;
        logic [DCNT_W-1:0]   r_cnt;
        logic [DCNT_W-1:0]   w_ncnt;
        logic                r_filt;
        logic                w_nfilt;
        logic                r_c2p;
        logic                r_en;
        logic [NUM_FUNC-1:0] r_in;

        assign w_out = func_out_i[p*NUM_FUNC +: NUM_FUNC];
        assign w_oen = func_oen_i[p*NUM_FUNC +: NUM_FUNC];
        assign w_wr  = cfg_we_i && (cfg_idx_i == IDX_W'(p));

        // Next-state logic; a write during DRAIN always restarts the dead time.
        always_comb begin
            w_nstate = r_state;
            w_nsel   = r_sel;
            w_npend  = r_pend;
            w_ncnt   = r_cnt;
            w_nfilt  = r_filt;
            if (w_wr) begin
                w_nfilt = cfg_filt_i;
            end
            case (r_state)
                ST_ACTIVE: begin
                    if (w_wr && (cfg_sel_i != r_sel)) begin
                        w_nstate = ST_DRAIN;
                        w_npend  = cfg_sel_i;
                        w_ncnt   = DCNT_W'(DEAD_CYC - 1);
                    end
                end
                ST_DRAIN: begin
                    if (w_wr) begin
                        w_npend = cfg_sel_i;
                        w_ncnt  = DCNT_W'(DEAD_CYC - 1);
                    end else if (r_cnt == '0) begin
                        w_nstate = ST_ACTIVE;
                        w_nsel   = r_pend;
                    end else begin
                        w_ncnt = r_cnt - DCNT_W'(1);
                    end
                end
                default: begin
                    w_nstate = ST_ACTIVE;
                end
            endcase
        end

        assign w_nactive = (w_nstate == ST_ACTIVE);
        assign w_sel_oh  = NUM_FUNC'(1) << w_nsel;

        io_pad_in_filter #(
            .FILT_CYC (FILT_CYC)
        ) u_filt (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .pad_i     (pad_p2c_i[p]),
            .filt_i    (r_filt),
            .val_nxt_c (w_val_nxt)
        );

        // Outputs are registered from next-state values so the enable drops the cycle after a write.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_state <= ST_ACTIVE;
                r_sel   <= SEL_W'(FUNC_GPIO);
                r_pend  <= SEL_W'(FUNC_GPIO);
                r_cnt   <= '0;
                r_filt  <= 1'b0;
                r_c2p   <= 1'b0;
                r_en    <= 1'b0;
                r_in    <= '0;
            end else begin
                r_state <= w_nstate;
                r_sel   <= w_nsel;
                r_pend  <= w_npend;
                r_cnt   <= w_ncnt;
                r_filt  <= w_nfilt;
                r_c2p   <= w_out[w_nsel];
                r_en    <= w_oen[w_nsel] & w_nactive;
                r_in    <= w_nactive ? (w_sel_oh & {NUM_FUNC{w_val_nxt}}) : '0;
            end
        end

        assign pad_c2p_o[p]                    = r_c2p;
        assign pad_c2p_en_o[p]                 = r_en;
        assign func_in_o[p*NUM_FUNC +: NUM_FUNC] = r_in;
        assign sel_o[p*SEL_W +: SEL_W]         = r_sel;
        assign busy_o[p]                       = (r_state == ST_DRAIN);
    end

endmodule
